// File: rtl/jt51_kon_wr.sv
// jt51_kon_wr: key-on write queue and update strobe generator.
//
// CPU key-on writes (register 0x08 format) are pushed into a small FIFO.
// Commands leave the FIFO one at a time. Each one drives keyon_op/keyon_ch
// and holds up_keyon high for HOLD cen-qualified cycles. That is one full
// operator round, so the 32-stage per-slot key-on shift register sees all
// four operators of the target channel.
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-high
//   cen       slot-sequencer clock enable (gates issue/hold timing only)
//   wr_valid  write request
//   wr_ready  FIFO can accept (!full)
//   wr_data   [6:3] operator mask {C2,M2,C1,M1}, [2:0] channel
//   keyon_op  issued operator mask (bit0 M1, bit1 C1, bit2 M2, bit3 C2)
//   keyon_ch  issued channel
//   up_keyon  update strobe, high for HOLD cen cycles per command
//   busy      up_keyon or FIFO non-empty
//   level     FIFO occupancy
//
// Optional feature macro: JT51_KON_MERGE_EN
//   Defined:   a push whose channel matches the newest queued entry
//              overwrites that entry's mask instead of enqueuing.
//   Undefined: every accepted write enqueues.

module jt51_kon_wr #(
  parameter int DEPTH = 4,   // FIFO entries, power of two, >= 2
  parameter int HOLD  = 32   // cen cycles per command, equals slot count
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cen,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [6:0]               wr_data,
  output logic [3:0]               keyon_op,
  output logic [2:0]               keyon_ch,
  output logic                     up_keyon,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(HOLD + 1);

  localparam logic [CW-1:0] CNT_LOAD   = CW'(HOLD - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [6:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [0:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic [3:0]    keyon_op_r;
  logic [2:0]    keyon_ch_r;
  logic          up_keyon_r;

  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic          merge_s;
  logic          enq_s;
  logic [AW-1:0] wr_idx_s;

  assign empty_s = (level_r == {LW{1'b0}});
  assign full_s  = (level_r == LEVEL_FULL);
  assign push_s  = wr_valid && !full_s;

  // The head leaves the FIFO when the sequencer is idle, or exactly when the
  // running command's hold count has expired (back-to-back issue).
  assign pop_s = cen && !empty_s &&
                 ((state_r == ST_IDLE) || (cnt_r == {CW{1'b0}}));

`ifdef JT51_KON_MERGE_EN
  logic [AW-1:0] newest_s;
  assign newest_s = wr_ptr_r - PTR_ONE;
  // Merge only into a still-queued entry; if the lone entry is leaving on
  // this edge, the write must enqueue behind it instead.
  assign merge_s  = push_s && !empty_s &&
                    (mem_r[newest_s][2:0] == wr_data[2:0]) &&
                    !(pop_s && (level_r == LEVEL_ONE));
  assign wr_idx_s = merge_s ? newest_s : wr_ptr_r;
`else
  assign merge_s  = 1'b0;
  assign wr_idx_s = wr_ptr_r;
`endif

  assign enq_s = push_s && !merge_s;

  // FIFO storage: an accepted write lands at the tail, or on the newest entry when merging.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_idx_s] <= wr_data;
    end
  end

  // FIFO pointers and occupancy counter (level kept separately so full/empty never alias).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (enq_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({enq_s, pop_s})
        2'b10:   level_r <= level_r + LEVEL_ONE;
        2'b01:   level_r <= level_r - LEVEL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Issue sequencer: loads the head into the outputs and times the up_keyon hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CW{1'b0}};
      keyon_op_r <= 4'h0;
      keyon_ch_r <= 3'd0;
      up_keyon_r <= 1'b0;
    end else if (cen) begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            keyon_op_r <= mem_r[rd_ptr_r][6:3];
            keyon_ch_r <= mem_r[rd_ptr_r][2:0];
            up_keyon_r <= 1'b1;
            cnt_r      <= CNT_LOAD;
            state_r    <= ST_HOLD;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          end else if (pop_s) begin
            keyon_op_r <= mem_r[rd_ptr_r][6:3];
            keyon_ch_r <= mem_r[rd_ptr_r][2:0];
            cnt_r      <= CNT_LOAD;
          end else begin
            // Last command done: drop the strobe, keep op/ch for observation.
            up_keyon_r <= 1'b0;
            state_r    <= ST_IDLE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          cnt_r      <= {CW{1'b0}};
          up_keyon_r <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  assign keyon_op = keyon_op_r;
  assign keyon_ch = keyon_ch_r;
  assign up_keyon = up_keyon_r;
  assign busy     = up_keyon_r || !empty_s;
  assign wr_ready = !full_s;
  assign level    = level_r;

endmodule

// File: tb/tb_jt51_kon_wr.sv
module tb_jt51_kon_wr;

  localparam int DEPTH = 4;
  localparam int HOLD  = 32;
`ifdef JT51_KON_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cen;
  logic       wr_valid;
  logic       wr_ready;
  logic [6:0] wr_data;
  logic [3:0] keyon_op;
  logic [2:0] keyon_ch;
  logic       up_keyon;
  logic       busy;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  jt51_kon_wr #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .keyon_op(keyon_op), .keyon_ch(keyon_ch), .up_keyon(up_keyon),
    .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending commands plus the command on air,
  // which stays on air for HOLD enabled clock edges.
  logic [6:0] m_q[$];
  bit         m_active;
  int         m_remain;
  logic [3:0] m_op;
  logic [2:0] m_ch;
  bit         m_issued;

  task automatic model_clear();
    m_q.delete();
    m_active = 1'b0;
    m_remain = 0;
    m_op     = 4'h0;
    m_ch     = 3'd0;
    m_issued = 1'b0;
  endtask

  task automatic model_issue();
    logic [6:0] e;
    e        = m_q.pop_front();
    m_op     = e[6:3];
    m_ch     = e[2:0];
    m_active = 1'b1;
    m_remain = HOLD;
    m_issued = 1'b1;
  endtask

  task automatic model_edge(input logic c, input logic v, input logic [6:0] d);
    bit acc;
    acc      = v && (m_q.size() < DEPTH);
    m_issued = 1'b0;
    if (c) begin
      if (m_active) begin
        m_remain--;
        if (m_remain == 0) begin
          if (m_q.size() > 0) model_issue();
          else m_active = 1'b0;
        end
      end else if (m_q.size() > 0) begin
        model_issue();
      end
    end
    if (acc) begin
      if (MERGE && m_q.size() > 0 && m_q[$][2:0] == d[2:0]) m_q[$] = d;
      else m_q.push_back(d);
    end
  endtask

  task automatic step(input logic c, input logic v, input logic [6:0] d);
    cen = c; wr_valid = v; wr_data = d;
    @(posedge clk);
    model_edge(c, v, d);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (m_active || m_q.size() > 0); i++) step(1'b1, 1'b0, 7'h00);
  endtask

  task automatic test_reset();
    checks++; if (up_keyon !== 1'b0) begin errors++; $display("FAIL rst_up got %b exp 0", up_keyon); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
    checks++; if (keyon_op !== 4'h0 || keyon_ch !== 3'd0) begin errors++; $display("FAIL rst_opch got %h/%0d exp 0/0", keyon_op, keyon_ch); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", wr_ready); end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    step(1'b1, 1'b0, 7'h00);
    checks++; if (up_keyon !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post_rst_idle got %b%b exp 00", up_keyon, busy); end
  endtask

  task automatic test_single();
    int first = -1;
    int hi = 0;
    step(1'b1, 1'b1, 7'h7B);
    checks++; if (up_keyon !== 1'b0) begin errors++; $display("FAIL single_latency got %b exp 0", up_keyon); end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 7'h00);
      checks++; if (up_keyon !== m_active) begin errors++; $display("FAIL single_up cyc %0d got %b exp %b", i, up_keyon, m_active); end
      checks++; if (busy !== (m_active || m_q.size() > 0)) begin errors++; $display("FAIL single_busy cyc %0d got %b", i, busy); end
      if (up_keyon) begin hi++; if (first < 0) first = i; end
    end
    checks++; if (first !== 0) begin errors++; $display("FAIL single_start got %0d exp 0", first); end
    checks++; if (hi !== HOLD) begin errors++; $display("FAIL single_len got %0d exp %0d", hi, HOLD); end
    checks++; if (keyon_op !== 4'hF || keyon_ch !== 3'd3) begin errors++; $display("FAIL single_opch got %h/%0d exp f/3", keyon_op, keyon_ch); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_cen_div();
    int hi = 0;
    step(1'b1, 1'b1, 7'h35);
    for (int i = 0; i < 110; i++) begin
      step(1'(i % 3 == 2), 1'b0, 7'h00);
      checks++; if (up_keyon !== m_active) begin errors++; $display("FAIL cen_up cyc %0d got %b exp %b", i, up_keyon, m_active); end
      if (up_keyon) hi++;
    end
    checks++; if (hi !== 3 * HOLD) begin errors++; $display("FAIL cen_len got %0d exp %0d", hi, 3 * HOLD); end
    checks++; if (keyon_op !== 4'h6 || keyon_ch !== 3'd5) begin errors++; $display("FAIL cen_opch got %h/%0d exp 6/5", keyon_op, keyon_ch); end
    drain();
  endtask

  task automatic test_burst();
    logic [2:0] got[$];
    int hi = 0;
    int rises = 0;
    logic prev = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, {4'(k + 1), 3'(k)});
      if (m_issued) got.push_back(keyon_ch);
      if (up_keyon && !prev) rises++;
      if (up_keyon) hi++;
      prev = up_keyon;
    end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL burst_full got %0d exp 4", level); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL burst_ready got %b exp 0", wr_ready); end
    step(1'b1, 1'b1, 7'h7F);
    if (up_keyon) hi++;
    prev = up_keyon;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL burst_reject got %0d exp 4", level); end
    for (int i = 0; i < 220; i++) begin
      step(1'b1, 1'b0, 7'h00);
      if (m_issued) got.push_back(keyon_ch);
      checks++; if (level !== 3'(m_q.size())) begin errors++; $display("FAIL burst_level cyc %0d got %0d exp %0d", i, level, m_q.size()); end
      if (up_keyon && !prev) rises++;
      if (up_keyon) hi++;
      prev = up_keyon;
    end
    checks++; if (hi !== 5 * HOLD) begin errors++; $display("FAIL burst_len got %0d exp %0d", hi, 5 * HOLD); end
    checks++; if (rises !== 1) begin errors++; $display("FAIL burst_gap got %0d exp 1", rises); end
    checks++; if (got.size() !== 5) begin errors++; $display("FAIL burst_count got %0d exp 5", got.size()); end
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      checks++; if (got[k] !== 3'(k)) begin errors++; $display("FAIL burst_order idx %0d got %0d exp %0d", k, got[k], k); end
    end
  endtask

  task automatic test_push_pop();
    logic [6:0] exp_l[3] = '{7'h11, 7'h22, 7'h43};
    logic [6:0] got[$];
    step(1'b1, 1'b1, 7'h08);
    step(1'b1, 1'b1, 7'h11);
    step(1'b1, 1'b1, 7'h22);
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL pp_pre got %0d exp 2", level); end
    for (int i = 0; i < 40 && !(m_active && m_remain == 1); i++) step(1'b1, 1'b0, 7'h00);
    step(1'b1, 1'b1, 7'h43);
    if (m_issued) got.push_back({keyon_op, keyon_ch});
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL pp_level got %0d exp 2", level); end
    for (int i = 0; i < 200 && (m_active || m_q.size() > 0); i++) begin
      step(1'b1, 1'b0, 7'h00);
      if (m_issued) got.push_back({keyon_op, keyon_ch});
    end
    checks++; if (got.size() !== 3) begin errors++; $display("FAIL pp_count got %0d exp 3", got.size()); end
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      checks++; if (got[k] !== exp_l[k]) begin errors++; $display("FAIL pp_order idx %0d got %h exp %h", k, got[k], exp_l[k]); end
    end
  endtask

  task automatic test_reset_mid();
    int hi = 0;
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, {4'hA, 3'(k + 4)});
    for (int i = 0; i < 40 && m_remain > 11; i++) step(1'b1, 1'b0, 7'h00);
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL rmid_level got %0d exp 3", level); end
    #2 rst = 1'b1;
    #1;
    checks++; if (up_keyon !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_up got %b%b exp 00", up_keyon, busy); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rmid_lvl got %0d exp 0", level); end
    checks++; if (keyon_op !== 4'h0 || keyon_ch !== 3'd0) begin errors++; $display("FAIL rmid_opch got %h/%0d exp 0/0", keyon_op, keyon_ch); end
    @(posedge clk); #1 rst = 1'b0;
    model_clear();
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 1'b0, 7'h00);
      if (up_keyon || busy) hi++;
    end
    checks++; if (hi !== 0) begin errors++; $display("FAIL rmid_quiet got %0d exp 0", hi); end
  endtask

  task automatic test_merge();
    logic [6:0] got[$];
    logic [6:0] exp_l[$];
    if (MERGE) exp_l = '{7'h79, 7'h1A, 7'h45};
    else       exp_l = '{7'h79, 7'h1A, 7'h0D, 7'h45};
    step(1'b1, 1'b1, 7'h79);
    step(1'b1, 1'b1, 7'h1A);
    if (m_issued) got.push_back({keyon_op, keyon_ch});
    step(1'b1, 1'b1, 7'h0D);
    step(1'b1, 1'b1, 7'h45);
    checks++; if (level !== (MERGE ? 3'd2 : 3'd3)) begin errors++; $display("FAIL merge_level got %0d exp %0d", level, MERGE ? 2 : 3); end
    for (int i = 0; i < 200 && (m_active || m_q.size() > 0); i++) begin
      step(1'b1, 1'b0, 7'h00);
      if (m_issued) got.push_back({keyon_op, keyon_ch});
    end
    checks++; if (got.size() !== exp_l.size()) begin errors++; $display("FAIL merge_count got %0d exp %0d", got.size(), exp_l.size()); end
    for (int k = 0; k < exp_l.size() && k < got.size(); k++) begin
      checks++; if (got[k] !== exp_l[k]) begin errors++; $display("FAIL merge_order idx %0d got %h exp %h", k, got[k], exp_l[k]); end
    end
  endtask

  task automatic test_random();
    logic       c;
    logic       v;
    logic [6:0] d;
    for (int i = 0; i < 1500; i++) begin
      c = 1'($urandom_range(0, 9) < 7);
      v = 1'($urandom_range(0, 3) == 0);
      d = {4'($urandom_range(0, 15)), 3'($urandom_range(0, 2))};
      step(c, v, d);
      checks++;
      if (up_keyon !== m_active || busy !== (m_active || m_q.size() > 0) ||
          level !== 3'(m_q.size()) || wr_ready !== (m_q.size() < DEPTH) ||
          keyon_op !== m_op || keyon_ch !== m_ch) begin
        errors++;
        $display("FAIL rand cyc %0d got up%b busy%b lvl%0d rdy%b op%h ch%0d exp up%b lvl%0d op%h ch%0d",
                 i, up_keyon, busy, level, wr_ready, keyon_op, keyon_ch, m_active, m_q.size(), m_op, m_ch);
      end
    end
    drain();
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0; wr_valid = 1'b0; wr_data = 7'h00;
    model_clear();
    #3;
    test_reset();
    test_single();
    test_cen_div();
    test_burst();
    test_push_pop();
    test_reset_mid();
    test_merge();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt51_kon_wr.md
Name: jt51_kon_wr

Overview:
- Producer side of the key-on update interface. Takes CPU key-on writes in register 0x08 format and queues them in a small FIFO.
- Issues one command at a time as keyon_ch / keyon_op / up_keyon.
- up_keyon is held for one full 32-slot operator round, so the per-slot key-on shift register (32 stages) captures all four operators of the target channel.
- Sits between the MMR write decoder and the key-on tracking block.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- HOLD, 32, cen-qualified cycles per command that up_keyon stays high; must equal the slot count.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cen  in  1  clock enable for the slot sequencer; gates issue and hold timing only
- wr_valid  in  1  write request
- wr_ready  out  1  FIFO can accept; equals !full
- wr_data  in  7  [6:3] operator mask {C2,M2,C1,M1}, [2:0] channel
- keyon_op  out  4  issued mask: bit0 M1, bit1 C1, bit2 M2, bit3 C2 (equals wr_data[6:3])
- keyon_ch  out  3  issued channel
- up_keyon  out  1  update strobe, high for exactly HOLD cen cycles per command
- busy  out  1  up_keyon || FIFO non-empty
- level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async): FIFO empty, level=0, keyon_op=0, keyon_ch=0, up_keyon=0, busy=0, FSM=IDLE, hold counter=0. Reset mid-HOLD drops the active command and all queued commands immediately.
- Push: on any clk edge where wr_valid && wr_ready; independent of cen.
  - wr_ready=0 when level==DEPTH; writes offered then are not accepted and are not retried by this block.
- FSM, all transitions on clk edges with cen=1:
  - IDLE: FIFO non-empty -> pop head into keyon_op/keyon_ch, up_keyon<=1, cnt<=HOLD-1, go HOLD.
  - HOLD, cnt!=0: cnt<=cnt-1.
  - HOLD, cnt==0, FIFO non-empty: pop next entry back-to-back; up_keyon stays 1, cnt<=HOLD-1.
  - HOLD, cnt==0, FIFO empty: up_keyon<=0, go IDLE. keyon_op/keyon_ch keep their last value.
- With cen=0 the FSM, counter and outputs hold; pushes still occur.
- Latency: with cen tied high, a write accepted at edge N into an empty, idle block gives up_keyon=1 after edge N+1. A push and a pop on the same edge are never combined into a single-cycle bypass.
- Simultaneous push and pop: both take effect; level unchanged; FIFO order preserved.
- Pointers wrap modulo DEPTH; level is kept as a separate counter so full and empty are unambiguous.
- busy is registered-equivalent: computed from registered state only.

Optional Feature:
- Macro: JT51_KON_MERGE_EN.
- Defined: a push whose channel equals the channel of the newest FIFO entry overwrites that entry's mask instead of enqueuing; level does not change.
  - Merge is not performed if that entry is being popped on the same edge (it then enqueues normally).
  - Merge is never performed into the active (issued) command.
  - wr_ready is still !full.
- Undefined: every accepted write enqueues.

Test Plan:
- Single write, cen=1: wr_data=7'h7B (mask 4'hF, ch 3) -> up_keyon high exactly 32 cycles starting one cycle after acceptance; keyon_op=4'hF, keyon_ch=3; busy falls with up_keyon.
- cen=1 every 3rd clk: one write -> up_keyon held for 32 cen pulses (96 clks); no state change on cen=0 edges.
- Burst of 5 writes (ch 0..4), DEPTH=4: first issues at once; second through fifth queue, level reaches 4, wr_ready=0 while full. Commands issue back-to-back, up_keyon continuous for 160 cycles, channels in order 0,1,2,3,4.
- Push coinciding with pop at level=2 -> level stays 2; issue order intact.
- Reset asserted at hold count 10 with level=3 -> all outputs 0 asynchronously; after release no up_keyon until a new write.
- Merge enabled: writes ch5 mask 1, ch5 mask 8 while the FIFO holds entry ch2 -> level increments once; ch5 issues with keyon_op=4'h8. Merge disabled: ch5 issues twice, with masks 1 then 8.
